// File: rtl/gauss_mac_sched.sv
// Time-shares one external 8x8 multiplier across the nine taps of a 3x3 Gaussian kernel,
// accumulates the products, then normalises and saturates them to one output pixel per window.
module gauss_mac_sched #(
    parameter logic [71:0] KERNEL = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1},
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned ACC_W  = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [71:0] i_in_win,
    output logic [7:0]  o_mul_a,
    output logic [7:0]  o_mul_b,
    input  logic [15:0] i_mul_p,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_out_pix,
    output logic        o_busy
);

    // state | meaning
    // IDLE  | waiting for a window, in_ready high
    // RUN   | one kernel tap per cycle through the multiplier (idx 0..8)
    // DONE  | result held on out_pix until downstream takes it
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [71:0]        r_win;
    logic [ACC_W-1:0]   r_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [7:0]         r_out_pix;

    logic [6:0]         w_tap_lsb;
    logic [ACC_W-1:0]   w_acc_sum;
    logic [ACC_W-1:0]   w_shifted;
    logic [7:0]         w_sat;

    assign w_tap_lsb = {r_idx, 3'b000};
    assign w_acc_sum = r_acc + {{(ACC_W-16){1'b0}}, i_mul_p};
    assign w_shifted = w_acc_sum >> SHIFT;
    assign w_sat     = (w_shifted > ACC_W'(255)) ? 8'hFF : w_shifted[7:0];

    // Operands come straight from registers so the external multiplier sees a full cycle.
    assign o_mul_a     = (r_state == S_RUN) ? r_win[w_tap_lsb +: 8]  : 8'd0;
    assign o_mul_b     = (r_state == S_RUN) ? KERNEL[w_tap_lsb +: 8] : 8'd0;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_pix   = r_out_pix;
    assign o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_win       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pix   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (i_in_valid && r_in_ready) begin
                        r_win      <= i_in_win;
                        r_acc      <= '0;
                        r_idx      <= 4'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_sum;
                    if (r_idx == 4'd8) begin
                        r_idx       <= 4'd0;
                        r_out_pix   <= w_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= 4'd0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_mac_sched.sv
// Directed bench for gauss_mac_sched: three instances (SHIFT 4, 2, 0) share the same
// stimulus, each with a behavioural combinational multiplier on its operand ports.
module tb_gauss_mac_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [71:0] in_win;
    logic        out_ready;

    logic        in_ready4, in_ready2, in_ready0;
    logic [7:0]  mul_a4, mul_b4, mul_a2, mul_b2, mul_a0, mul_b0;
    logic [15:0] mul_p4, mul_p2, mul_p0;
    logic        out_valid4, out_valid2, out_valid0;
    logic [7:0]  out_pix4, out_pix2, out_pix0;
    logic        busy4, busy2, busy0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [71:0] win;
        logic [7:0]  e4;
        logic [7:0]  e2;
        logic [7:0]  e0;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] coef[9] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};

    always #5 clk = ~clk;

    assign mul_p4 = {8'd0, mul_a4} * {8'd0, mul_b4};
    assign mul_p2 = {8'd0, mul_a2} * {8'd0, mul_b2};
    assign mul_p0 = {8'd0, mul_a0} * {8'd0, mul_b0};

    gauss_mac_sched #(.SHIFT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready4),
        .i_in_win(in_win), .o_mul_a(mul_a4), .o_mul_b(mul_b4), .i_mul_p(mul_p4),
        .o_out_valid(out_valid4), .i_out_ready(out_ready), .o_out_pix(out_pix4), .o_busy(busy4)
    );

    gauss_mac_sched #(.SHIFT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
        .i_in_win(in_win), .o_mul_a(mul_a2), .o_mul_b(mul_b2), .i_mul_p(mul_p2),
        .o_out_valid(out_valid2), .i_out_ready(out_ready), .o_out_pix(out_pix2), .o_busy(busy2)
    );

    gauss_mac_sched #(.SHIFT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .i_in_win(in_win), .o_mul_a(mul_a0), .o_mul_b(mul_b0), .i_mul_p(mul_p0),
        .o_out_valid(out_valid0), .i_out_ready(out_ready), .o_out_pix(out_pix0), .o_busy(busy0)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"},  {15'd0, in_ready4},  16'd0);
        chk({tag, " out_valid"}, {15'd0, out_valid4}, 16'd0);
        chk({tag, " out_pix"},   {8'd0, out_pix4},    16'd0);
        chk({tag, " busy"},      {15'd0, busy4},      16'd0);
        chk({tag, " mul_a"},     {8'd0, mul_a4},      16'd0);
        chk({tag, " mul_b"},     {8'd0, mul_b4},      16'd0);
        chk({tag, " out_pix s0"}, {8'd0, out_pix0},   16'd0);
    endtask

    // Called at a negedge with all three instances idle and ready.
    task automatic run_vec(input int v);
        logic [71:0] w;
        w = vecs[v].win;
        chk($sformatf("v%0d idle in_ready", v), {15'd0, in_ready4}, 16'd1);
        in_win    = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("v%0d mul_a tap%0d", v, t), {8'd0, mul_a4}, {8'd0, w[t*8 +: 8]});
            chk($sformatf("v%0d mul_b tap%0d", v, t), {8'd0, mul_b4}, {8'd0, coef[t]});
            chk($sformatf("v%0d early out_valid tap%0d", v, t), {15'd0, out_valid4}, 16'd0);
            chk($sformatf("v%0d run busy/ready tap%0d", v, t), {14'd0, busy4, in_ready4}, 16'd2);
            @(negedge clk);
        end
        chk($sformatf("v%0d out_valid at edge 9", v), {13'd0, out_valid4, out_valid2, out_valid0}, 16'd7);
        chk($sformatf("v%0d out_pix shift4", v), {8'd0, out_pix4}, {8'd0, vecs[v].e4});
        chk($sformatf("v%0d out_pix shift2", v), {8'd0, out_pix2}, {8'd0, vecs[v].e2});
        chk($sformatf("v%0d out_pix shift0", v), {8'd0, out_pix0}, {8'd0, vecs[v].e0});
        chk($sformatf("v%0d done mul_a", v), {8'd0, mul_a4}, 16'd0);
        @(negedge clk);
        chk($sformatf("v%0d back idle", v), {13'd0, out_valid4, in_ready4, busy4}, 16'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // acc = weighted sum with kernel 1 2 1 / 2 4 2 / 1 2 1
        vecs[0] = '{win: {9{8'hFF}},                                   e4: 8'd255, e2: 8'd255, e0: 8'd255}; // 4080
        vecs[1] = '{win: 72'(16) << 32,                                e4: 8'd4,   e2: 8'd16,  e0: 8'd64};  // 64
        vecs[2] = '{win: {8'd8,8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1,8'd0}, e4: 8'd4, e2: 8'd16,  e0: 8'd64};  // 64
        vecs[3] = '{win: {9{8'd63}},                                   e4: 8'd63,  e2: 8'd252, e0: 8'd255}; // 1008
        vecs[4] = '{win: {9{8'd64}},                                   e4: 8'd64,  e2: 8'd255, e0: 8'd255}; // 1024
        vecs[5] = '{win: 72'(200),                                     e4: 8'd12,  e2: 8'd50,  e0: 8'd200}; // 200
        vecs[6] = '{win: 72'(255) << 8,                                e4: 8'd31,  e2: 8'd127, e0: 8'd255}; // 510
        vecs[7] = '{win: {9{8'd15}},                                   e4: 8'd15,  e2: 8'd60,  e0: 8'd240}; // 240
        vecs[8] = '{win: 72'(7) << 64,                                 e4: 8'd0,   e2: 8'd1,   e0: 8'd7};   // 7

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_win    = {9{8'hFF}};
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", {15'd0, in_ready4}, 16'd1);
        chk("in_valid at release not taken", {15'd0, busy4}, 16'd0);
        in_valid = 1'b0;

        for (int v = 0; v < 9; v++) run_vec(v);

        // Downstream stall: result must hold and upstream windows must be ignored.
        in_win    = {8'd8,8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1,8'd0};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("stall%0d valid/ready", c), {14'd0, out_valid4, in_ready4}, 16'd2);
            chk($sformatf("stall%0d out_pix", c), {8'd0, out_pix4}, 16'd4);
            in_valid = c[0];
            in_win   = {9{8'hFF}};
            @(negedge clk);
        end
        in_win    = {9{8'd63}};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall release idle", {13'd0, out_valid4, in_ready4, busy4}, 16'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next window accepted", {14'd0, busy4, in_ready4}, 16'd2);
        repeat (9) @(negedge clk);
        chk("post-stall out_valid", {15'd0, out_valid4}, 16'd1);
        chk("post-stall out_pix", {8'd0, out_pix4}, 16'd63);
        @(negedge clk);

        // Reset in the middle of RUN discards the partial sum.
        in_win   = {9{8'hFF}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-run idx5 mul_a", {8'd0, mul_a4}, 16'd255);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid-run reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no output after reset", {15'd0, out_valid4}, 16'd0);
        run_vec(1);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
